// File: rtl/pipelinestages_pkg.sv
// Shared pipeline record types for the EX/MEM/WB boundary, plus the
// memory-stage FSM encoding and data-memory request layout.
package pipelinestages_pkg;

  localparam int XLEN = 32;

  // Record handed from EX/MEM into the memory stage.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
  } ex_mem_t;

  // Record handed from the memory stage into writeback.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_or_mem_val;
    logic [4:0]      rd;
    logic            reg_write;
  } mem_wb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_stage_state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

  // A record touches data memory if it reads or writes it.
  function automatic logic is_mem_op(input ex_mem_t r);
    return r.mem_read | r.mem_write;
  endfunction

endpackage

// File: rtl/mem_stage_timeout.sv
// Response watchdog for mem_stage: a loadable down-counter. It is loaded
// with TIMEOUT_CYCLES when a request is handed to memory and decrements on
// every waiting cycle; expire flags the last allowed waiting cycle so the
// owner can abort on that same clock edge. TIMEOUT_CYCLES = 0 disables it.
module mem_stage_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, load, dec};
    assign expire = 1'b0;
  end else begin : g_on
    logic [CW-1:0] cnt;

    // Reload on request handshake, count down while waiting for a response.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (load) begin
        cnt <= CW'(TIMEOUT_CYCLES);
      end else if (dec && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end

    assign expire = dec && (cnt == CW'(1));
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Accepts an ex_mem_t record, performs at most
// one outstanding data-memory transaction (valid/ready request, one-cycle
// valid response) and registers a mem_wb_t record for writeback.
// Optional feature: define MEM_STAGE_MISALIGN_CHECK_EN to retire misaligned
// memory records immediately (reg_write cleared, misalign_err pulsed)
// instead of issuing them.
module mem_stage
  import pipelinestages_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  ex_mem_t     in_stage,
  output logic        in_ready,
  output mem_wb_t     out_stage,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        dmem_timeout,
  output logic        misalign_err
);

  mem_stage_state_t state, state_nxt;

  logic      accept;
  logic      mem_op;
  logic      misalign_hit;
  logic      issue;
  logic      retire_now;
  logic      rsp_done;
  logic      tmo_expire;

  // Transaction context captured at accept, held until the record retires.
  dmem_req_t req_p1;
  logic [4:0] rd_p1;
  logic      reg_write_p1;
  logic      mem_to_reg_p1;

  assign accept = in_stage.valid && in_ready;
  assign mem_op = is_mem_op(in_stage);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  assign misalign_hit = mem_op && (in_stage.alu_result[1:0] != 2'b00);
`else
  assign misalign_hit = 1'b0;
`endif

  // Memory records go out to memory; everything else accepted retires next cycle.
  assign issue      = accept && mem_op && !misalign_hit;
  assign retire_now = accept && !issue;
  assign rsp_done   = (state == RESP) && dmem_rsp_valid;

  mem_stage_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .load  ((state == REQ) && dmem_req_ready),
    .dec   ((state == RESP) && !dmem_rsp_valid),
    .expire(tmo_expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (issue) state_nxt = REQ;
      REQ:     if (dmem_req_ready) state_nxt = RESP;
      RESP:    if (dmem_rsp_valid || tmo_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    in_ready       = (state == IDLE);
    dmem_req_valid = (state == REQ);
  end

  // Latch request and writeback context when a memory record is issued.
  always_ff @(posedge clk) begin
    if (issue) begin
      req_p1.we     <= in_stage.mem_write;
      req_p1.addr   <= in_stage.alu_result;
      req_p1.wdata  <= in_stage.rs2;
      rd_p1         <= in_stage.rd;
      reg_write_p1  <= in_stage.reg_write;
      mem_to_reg_p1 <= in_stage.mem_to_reg;
    end
  end

  assign dmem_req_we    = req_p1.we;
  assign dmem_req_addr  = req_p1.addr;
  assign dmem_req_wdata = req_p1.wdata;

  // Writeback register: valid pulses once per retire, payload holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_stage    <= '0;
      dmem_timeout <= 1'b0;
    end else begin
      out_stage.valid <= 1'b0;
      dmem_timeout    <= tmo_expire;
      if (retire_now) begin
        out_stage.valid          <= 1'b1;
        out_stage.alu_or_mem_val <= in_stage.alu_result;
        out_stage.rd             <= in_stage.rd;
        out_stage.reg_write      <= in_stage.reg_write && !misalign_hit;
      end else if (rsp_done) begin
        out_stage.valid          <= 1'b1;
        out_stage.alu_or_mem_val <= mem_to_reg_p1 ? dmem_rsp_rdata : req_p1.addr;
        out_stage.rd             <= rd_p1;
        out_stage.reg_write      <= reg_write_p1;
      end else if (tmo_expire) begin
        out_stage.valid          <= 1'b1;
        out_stage.alu_or_mem_val <= req_p1.addr;
        out_stage.rd             <= rd_p1;
        out_stage.reg_write      <= 1'b0;
      end
    end
  end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  // Misalignment flag pulses alongside the aborted record's retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= accept && misalign_hit;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases followed by randomized
// transactions, with expected writeback records computed from the stage's
// transaction-level behaviour. Works with or without
// MEM_STAGE_MISALIGN_CHECK_EN defined.
module tb_mem_stage;
  import pipelinestages_pkg::*;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  ex_mem_t     in_stage;
  logic        in_ready;
  mem_wb_t     out_stage;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        dmem_timeout;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  // Last retired payload, for the hold-when-idle check.
  logic [31:0] last_val;
  logic [4:0]  last_rd;
  bit          last_known;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_stage       (in_stage),
    .in_ready       (in_ready),
    .out_stage      (out_stage),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .dmem_timeout   (dmem_timeout),
    .misalign_err   (misalign_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ex_mem_t rand_rec();
    ex_mem_t r;
    r.valid      = 1'b0;
    r.alu_result = $urandom;
    r.rs2        = $urandom;
    r.rd         = 5'($urandom);
    r.reg_write  = 1'($urandom);
    r.mem_read   = 1'($urandom);
    r.mem_write  = 1'($urandom);
    r.mem_to_reg = 1'($urandom);
    return r;
  endfunction

  // Expected writeback record for a record r, given how its memory access ended.
  function automatic mem_wb_t model_retire(input ex_mem_t r, input bit aborted,
                                           input logic [31:0] rdata);
    mem_wb_t e;
    bit mem;
    mem = r.mem_read || r.mem_write;
    e.valid          = 1'b1;
    e.rd             = r.rd;
    e.reg_write      = aborted ? 1'b0 : r.reg_write;
    e.alu_or_mem_val = (mem && r.mem_to_reg && !aborted) ? rdata : r.alu_result;
    return e;
  endfunction

  task automatic check_out(input string tag, input mem_wb_t e, input bit chk_val);
    chk({tag, ".valid"}, 64'(out_stage.valid), 64'(e.valid));
    chk({tag, ".rd"}, 64'(out_stage.rd), 64'(e.rd));
    chk({tag, ".reg_write"}, 64'(out_stage.reg_write), 64'(e.reg_write));
    if (chk_val) begin
      chk({tag, ".val"}, 64'(out_stage.alu_or_mem_val), 64'(e.alu_or_mem_val));
      last_val   = e.alu_or_mem_val;
      last_rd    = e.rd;
      last_known = 1'b1;
    end else begin
      last_known = 1'b0;
    end
  endtask

  // One cycle with no valid input; stray responses must be ignored.
  task automatic idle_cycle(input bit noise);
    in_stage       = rand_rec();
    dmem_rsp_valid = noise;
    dmem_rsp_rdata = $urandom;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("idle.out_valid", 64'(out_stage.valid), 64'd0);
    chk("idle.in_ready", 64'(in_ready), 64'd1);
    chk("idle.req_valid", 64'(dmem_req_valid), 64'd0);
    chk("idle.timeout", 64'(dmem_timeout), 64'd0);
    if (last_known) begin
      chk("idle.hold_val", 64'(out_stage.alu_or_mem_val), 64'(last_val));
      chk("idle.hold_rd", 64'(out_stage.rd), 64'(last_rd));
    end
  endtask

  // Drive one record through the stage, acting as the memory. rdly = cycles
  // ready stays low in REQ, sdly = response cycles waited in RESP (>= TMO times out).
  task automatic run_txn(input string tag, input ex_mem_t r, input int rdly,
                         input int sdly, input logic [31:0] rdata);
    bit mem;
    bit misal;
    int wait_n;
    mem   = r.mem_read || r.mem_write;
    misal = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    misal = mem && (r.alu_result[1:0] != 2'b00);
`endif
    chk({tag, ".accept_ready"}, 64'(in_ready), 64'd1);
    in_stage       = r;
    in_stage.valid = 1'b1;
    @(negedge clk);
    in_stage = rand_rec();
    if (!mem || misal) begin
      check_out(tag, model_retire(r, misal, 32'd0), !misal);
      chk({tag, ".misalign_err"}, 64'(misalign_err), 64'(misal));
      chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, ".no_req"}, 64'(dmem_req_valid), 64'd0);
    end else begin
      for (int i = 0; i <= rdly; i++) begin
        chk({tag, ".req_valid"}, 64'(dmem_req_valid), 64'd1);
        chk({tag, ".req_addr"}, 64'(dmem_req_addr), 64'(r.alu_result));
        chk({tag, ".req_we"}, 64'(dmem_req_we), 64'(r.mem_write));
        chk({tag, ".req_wdata"}, 64'(dmem_req_wdata), 64'(r.rs2));
        chk({tag, ".req_busy"}, 64'(in_ready), 64'd0);
        chk({tag, ".req_no_out"}, 64'(out_stage.valid), 64'd0);
        dmem_req_ready = (i == rdly);
        dmem_rsp_valid = 1'($urandom);
        dmem_rsp_rdata = $urandom;
        @(negedge clk);
      end
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      wait_n = (sdly < int'(TMO)) ? sdly : int'(TMO);
      for (int c = 0; c < wait_n; c++) begin
        chk({tag, ".resp_no_req"}, 64'(dmem_req_valid), 64'd0);
        chk({tag, ".resp_busy"}, 64'(in_ready), 64'd0);
        chk({tag, ".resp_no_out"}, 64'(out_stage.valid), 64'd0);
        @(negedge clk);
      end
      if (sdly < int'(TMO)) begin
        chk({tag, ".resp_busy"}, 64'(in_ready), 64'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = rdata;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = $urandom;
        check_out(tag, model_retire(r, 1'b0, rdata), 1'b1);
        chk({tag, ".no_timeout"}, 64'(dmem_timeout), 64'd0);
        chk({tag, ".ready_after"}, 64'(in_ready), 64'd1);
      end else begin
        check_out({tag, ".tmo"}, model_retire(r, 1'b1, rdata), 1'b0);
        chk({tag, ".timeout_pulse"}, 64'(dmem_timeout), 64'd1);
        chk({tag, ".ready_after"}, 64'(in_ready), 64'd1);
        // A late response must not produce a second retire.
        idle_cycle(1'b1);
      end
      chk({tag, ".misalign_err"}, 64'(misalign_err), 64'd0);
    end
  endtask

  initial begin
    ex_mem_t r;
    rst            = 1'b1;
    in_stage       = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    last_val       = '0;
    last_rd        = '0;
    last_known     = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.out_stage", 64'(out_stage), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.req_valid", 64'(dmem_req_valid), 64'd0);
    chk("rst.timeout", 64'(dmem_timeout), 64'd0);
    chk("rst.misalign", 64'(misalign_err), 64'd0);
    rst = 1'b0;
    idle_cycle(1'b0);

    // ALU record
    r = '0; r.alu_result = 32'h1234; r.rd = 5'd5; r.reg_write = 1'b1;
    run_txn("alu", r, 0, 0, 32'd0);
    idle_cycle(1'b0);

    // Load with delayed ready
    r = '0; r.alu_result = 32'h100; r.rd = 5'd7; r.reg_write = 1'b1;
    r.mem_read = 1'b1; r.mem_to_reg = 1'b1;
    run_txn("load", r, 3, 1, 32'hDEADBEEF);

    // Store, minimum latency
    r = '0; r.alu_result = 32'h20; r.rs2 = 32'hA5A5A5A5; r.mem_write = 1'b1;
    run_txn("store", r, 0, 0, 32'h0BADF00D);

    // Read and write both set: store wins
    r = '0; r.alu_result = 32'h44; r.rs2 = 32'h11223344; r.rd = 5'd3; r.reg_write = 1'b1;
    r.mem_read = 1'b1; r.mem_write = 1'b1;
    run_txn("rdwr", r, 1, 0, 32'h55667788);

    // Timeout with a late response
    r = '0; r.alu_result = 32'h80; r.rd = 5'd9; r.reg_write = 1'b1;
    r.mem_read = 1'b1; r.mem_to_reg = 1'b1;
    run_txn("timeout", r, 0, TMO + 2, 32'hCAFEF00D);

    // Back-to-back ALU records
    for (int k = 0; k < 3; k++) begin
      r = rand_rec(); r.mem_read = 1'b0; r.mem_write = 1'b0;
      run_txn("alu_b2b", r, 0, 0, 32'd0);
    end

    // Misaligned load at 0x102
    r = '0; r.alu_result = 32'h102; r.rd = 5'd4; r.reg_write = 1'b1;
    r.mem_read = 1'b1; r.mem_to_reg = 1'b1;
    run_txn("misalign", r, 0, 0, 32'h12345678);
    idle_cycle(1'b0);

    // Reset while a request is pending
    r = '0; r.alu_result = 32'h200; r.rd = 5'd2; r.reg_write = 1'b1; r.mem_read = 1'b1;
    in_stage = r; in_stage.valid = 1'b1;
    @(negedge clk);
    in_stage.valid = 1'b0;
    chk("rstmid.req_before", 64'(dmem_req_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid.req_dropped", 64'(dmem_req_valid), 64'd0);
    chk("rstmid.in_ready", 64'(in_ready), 64'd1);
    chk("rstmid.out_zero", 64'(out_stage), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_val = '0; last_rd = '0; last_known = 1'b1;
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      r = rand_rec();
      if ($urandom_range(0, 7) != 0) r.alu_result[1:0] = 2'b00;
      else r.alu_result[1:0] = 2'($urandom_range(1, 3));
      run_txn("rand", r, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), $urandom);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle_cycle(1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
